// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg
//   Shared definitions for the iterative barrel-shift sequencer:
//   - REGISTER_LEN : datapath width of the shifted operand
//   - COUNT_W      : width of the shift-step counter (holds up to 33)
//   - shift_type_e : LSL/LSR/ASR/ROR encodings, shared with decode logic
//   - effective_count() : number of 1-bit steps needed for a request
package shift_sequencer_pkg;

  localparam int REGISTER_LEN = 32;
  localparam int COUNT_W      = 6;
  localparam int AMOUNT_W     = 8;

  // Largest useful step count for LSL/LSR/ASR: 33 steps leaves LSL/LSR at
  // zero with a zero carry, and ASR saturated to sign fill.
  localparam logic [COUNT_W-1:0] MAX_LINEAR_COUNT = COUNT_W'(33);

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_type_e;

  // Rotates only care about the amount modulo the register width; linear
  // shifts saturate once every bit (and the carry) has been pushed out.
  function automatic logic [COUNT_W-1:0] effective_count(
    input logic [AMOUNT_W-1:0] amount,
    input logic [1:0]          kind
  );
    logic [COUNT_W-1:0] count;
    if (kind == SHIFT_ROR) begin
      count = {1'b0, amount[4:0]};
    end else if (amount > AMOUNT_W'(MAX_LINEAR_COUNT)) begin
      count = MAX_LINEAR_COUNT;
    end else begin
      count = amount[COUNT_W-1:0];
    end
    return count;
  endfunction

endpackage

// File: rtl/shift_sequencer_shift_step.sv
// shift_step
//   Combinational single-bit shifter used by the sequencer each SHIFT cycle.
//   Ports:
//     value_in   : current working value
//     shift_type : LSL / LSR / ASR / ROR
//     value_out  : value_in moved by exactly one bit position
//     carry_out  : the bit that left the word (ROR: old bit 0)
module shift_step
  import shift_sequencer_pkg::*;
(
  input  logic [REGISTER_LEN-1:0] value_in,
  input  logic [1:0]              shift_type,
  output logic [REGISTER_LEN-1:0] value_out,
  output logic                    carry_out
);

  logic [REGISTER_LEN-1:0] left_bits;
  logic [REGISTER_LEN-1:0] right_bits;
  logic                    top_fill;

  // What enters bit 31 on a right move: zero, the sign bit, or old bit 0.
  always_comb begin
    top_fill = 1'b0;
    case (shift_type)
      SHIFT_ASR: top_fill = value_in[REGISTER_LEN-1];
      SHIFT_ROR: top_fill = value_in[0];
      default:   top_fill = 1'b0;
    endcase
  end

  // Both neighbour views are built per bit so the final select is a plain
  // 2:1 mux per output bit.
  genvar gi;
  generate
    for (gi = 0; gi < REGISTER_LEN; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign left_bits[gi] = 1'b0;
      end else begin : g_lsb_n
        assign left_bits[gi] = value_in[gi-1];
      end

      if (gi == REGISTER_LEN - 1) begin : g_msb
        assign right_bits[gi] = top_fill;
      end else begin : g_msb_n
        assign right_bits[gi] = value_in[gi+1];
      end
    end
  endgenerate

  always_comb begin
    value_out = right_bits;
    carry_out = value_in[0];
    if (shift_type == SHIFT_LSL) begin
      value_out = left_bits;
      carry_out = value_in[REGISTER_LEN-1];
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Multi-cycle shifter: a request is accepted in IDLE, the operand is moved
//   one bit per cycle in SHIFT, and the result is presented with a one-cycle
//   done pulse. Upstream stages are frozen through stall while work remains.
//   Ports:
//     clk        : sole clock, all state on rising edge
//     rst        : synchronous active-high reset, highest priority
//     start      : request a shift (only honoured in IDLE)
//     flush      : abort the operation in progress / drop a request
//     rm         : operand to shift
//     rs_amount  : shift amount (Rs[7:0])
//     shift_type : LSL / LSR / ASR / ROR
//     carry_in   : current C flag
//     busy       : FSM is not in IDLE
//     stall      : combinational freeze request to upstream stages
//     done       : one-cycle pulse, result/carry_out valid
//     result     : shifted value, held until the next completion
//     carry_out  : shifter carry-out, held with result
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    flush,
  input  logic [REGISTER_LEN-1:0] rm,
  input  logic [AMOUNT_W-1:0]     rs_amount,
  input  logic [1:0]              shift_type,
  input  logic                    carry_in,
  output logic                    busy,
  output logic                    stall,
  output logic                    done,
  output logic [REGISTER_LEN-1:0] result,
  output logic                    carry_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]              state_reg;
  logic [1:0]              state_next;
  logic [COUNT_W-1:0]      count_reg;
  logic [REGISTER_LEN-1:0] work_reg;
  logic [1:0]              type_reg;
  logic [REGISTER_LEN-1:0] result_reg;
  logic                    carry_out_reg;

  logic                    accept;
  logic [COUNT_W-1:0]      start_count;
  logic                    start_carry;
  logic [REGISTER_LEN-1:0] step_value;
  logic                    step_carry;
  logic                    last_step;

  // ------------------------------------------------------------------
  // Request decode
  // ------------------------------------------------------------------
  assign accept      = (state_reg == ST_IDLE) && start && !flush;
  assign start_count = effective_count(rs_amount, shift_type);
  assign last_step   = (count_reg == COUNT_W'(1));

  // A zero-step request finishes straight from IDLE. For a rotate by a
  // non-zero multiple of 32 the carry is the operand's top bit; for every
  // other zero-step case (amount of 0) the C flag passes through.
  always_comb begin
    start_carry = carry_in;
    if (shift_type == SHIFT_ROR && rs_amount != '0 && rs_amount[4:0] == 5'd0) begin
      start_carry = rm[REGISTER_LEN-1];
    end
  end

  shift_step u_shift_step (
    .value_in   (work_reg),
    .shift_type (type_reg),
    .value_out  (step_value),
    .carry_out  (step_carry)
  );

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = (start_count == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else if (last_step) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs
  // ------------------------------------------------------------------
  always_comb begin
    busy  = (state_reg != ST_IDLE);
    done  = (state_reg == ST_DONE);
    stall = accept || (state_reg == ST_SHIFT);
  end

  // ------------------------------------------------------------------
  // Datapath: working value, counter and held result
  // ------------------------------------------------------------------
  // The result registers are written on the same edge that enters DONE, so
  // they are valid together with the done pulse. A flushed operation never
  // reaches that edge and the previous result stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg     <= '0;
      work_reg      <= '0;
      type_reg      <= SHIFT_LSL;
      result_reg    <= '0;
      carry_out_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            work_reg  <= rm;
            type_reg  <= shift_type;
            count_reg <= start_count;
            if (start_count == '0) begin
              result_reg    <= rm;
              carry_out_reg <= start_carry;
            end
          end
        end
        ST_SHIFT: begin
          if (flush) begin
            count_reg <= '0;
          end else begin
            work_reg  <= step_value;
            count_reg <= count_reg - COUNT_W'(1);
            if (last_step) begin
              result_reg    <= step_value;
              carry_out_reg <= step_carry;
            end
          end
        end
        default: begin
          count_reg <= '0;
        end
      endcase
    end
  end

  assign result    = result_reg;
  assign carry_out = carry_out_reg;

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1, request a register-specified shift; sampled only in IDLE.
REQ-004 SHALL have port flush, input, 1, abort any operation in progress (pipeline flush).
REQ-005 SHALL have port rm, input, REGISTER_LEN (32), operand to shift.
REQ-006 SHALL have port rs_amount, input, 8, shift amount (Rs[7:0]).
REQ-007 SHALL have port shift_type, input, 2, LSL/LSR/ASR/ROR encoding per shared shift-state defines.
REQ-008 SHALL have port carry_in, input, 1, current C flag.
REQ-009 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-010 SHALL have port stall, output, 1, combinational, = (start & IDLE & !flush) | SHIFT; freezes upstream stages.
REQ-011 SHALL have port done, output, 1, single-cycle pulse marking result valid.
REQ-012 SHALL have port result, output, 32, shifted value; held until next accepted start.
REQ-013 SHALL have port carry_out, output, 1, shifter carry-out; held with result.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 IDLE: start=1 and flush=0 SHALL latch rm, shift_type, carry_in, compute effective count N, and move to SHIFT if N>0, else to DONE.
REQ-016 N for LSL/LSR/ASR SHALL be min(rs_amount, 33); N for ROR SHALL be rs_amount[4:0].
REQ-017 SHIFT: each cycle SHALL shift the working value by exactly 1 bit, set working carry to the bit shifted out (ROR: bit rotated from [0]), decrement the 6-bit counter; after N shifts SHALL move to DONE.
REQ-018 LSL fills 0 from bit 0; LSR fills 0 from bit 31; ASR replicates bit 31; ROR moves bit 0 into bit 31.
REQ-019 N=0 with rs_amount=0 (any type) SHALL yield result=rm, carry_out=carry_in.
REQ-020 ROR with rs_amount!=0 and rs_amount[4:0]=0 SHALL yield result=rm, carry_out=rm[31].
REQ-021 Amount>=33 LSL/LSR SHALL yield result=0, carry_out=0; amount>=32 ASR SHALL yield all bits and carry_out = rm[31].
REQ-022 DONE: done=1 for exactly one cycle, result/carry_out updated from working registers on DONE entry, then unconditional return to IDLE.
REQ-023 Latency: done SHALL assert N+1 cycles after the cycle start is sampled.
REQ-024 start while busy SHALL be ignored; a request is accepted only in IDLE.
REQ-025 flush in SHIFT or DONE SHALL return to IDLE next cycle with no done pulse; result/carry_out keep previous values.
REQ-026 flush and start together in IDLE: flush wins, request dropped, stall=0.
REQ-027 Inputs rm, rs_amount, shift_type, carry_in SHALL be ignored after acceptance.

Reset
REQ-028 rst=1 at any edge, including mid-SHIFT, SHALL force IDLE, counter=0, done=0, busy=0, result=0, carry_out=0; rst has priority over flush and start.

Structure
REQ-029 REGISTER_LEN and LSL/LSR/ASR/ROR shift-state encodings SHALL come from the shared Defines.v; FSM state encodings SHALL be local parameters.
REQ-030 One sub-module, shift_step (combinational 1-bit shift plus carry, selected by shift_type), SHALL be instantiated once.

Verification
REQ-031 LSL rm=0x0000_0001, amount=4, carry_in=0 -> done after 5 cycles, result=0x10, carry_out=0.
REQ-032 ASR rm=0x8000_0000, amount=40 -> done after 34 cycles, result=0xFFFF_FFFF, carry_out=1.
REQ-033 ROR rm=0x0000_0003, amount=33 -> N=1, result=0x8000_0001, carry_out=1; ROR amount=32 rm=0x8000_0000 -> 1 cycle, result unchanged, carry_out=1.
REQ-034 LSR rm=0xFFFF_FFFF, amount=0, carry_in=1 -> done after 1 cycle, result=0xFFFF_FFFF, carry_out=1.
REQ-035 LSR amount=20, flush at 5th SHIFT cycle -> IDLE next cycle, no done, result holds prior value; new start accepted.
REQ-036 rst pulsed mid-SHIFT, start asserted while busy -> all outputs 0 after reset; busy-time start never produces done.
